// File: rtl/fifo_flagged_if.sv
// Producer/consumer bundle for fifo_flagged: write side, read side, status flags.
// The FIFO uses the slave modport; whoever drives it uses master.
interface fifo_flagged_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  clr;
    logic                  wren;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  rden;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wren, i_data, rden,
        input  o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wren, i_data, rden,
        output o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with registered or fall-through read, occupancy count,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_flagged #(
    parameter int DEPTH         = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input logic            clk,
    input logic            rst_n,
    fifo_flagged_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_flagged: DEPTH must be a power of 2 and >= 2");
    end
    if ((AFULL_THRESH < 0) || (AFULL_THRESH > DEPTH) ||
        (AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH)) begin : g_bad_thresh
        $error("fifo_flagged: thresholds must lie in 0..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  empty, full, rd_acc, wr_acc;
    logic [AW-1:0]         rd_idx, wr_idx;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign rd_acc = bus.rden & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_acc = bus.wren & (~full | rd_acc);
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
            ovf_d   = ovf_q | (bus.wren & ~wr_acc);
            udf_d   = udf_q | (bus.rden & empty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc && !bus.clr) mem_q[wr_idx] <= bus.i_data;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.o_data  = mem_q[rd_idx];
        assign bus.o_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvld_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
                rvld_q  <= 1'b0;
            end else if (bus.clr) begin
                rdata_q <= '0;
                rvld_q  <= 1'b0;
            end else begin
                rvld_q <= rd_acc;
                if (rd_acc) rdata_q <= mem_q[rd_idx];
            end
        end
        assign bus.o_data  = rdata_q;
        assign bus.o_valid = rvld_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench: registered-read FIFO (u_reg) and fall-through FIFO (u_fwft)
// sharing clock and reset, driven with hand-computed vectors.
module tb_fifo_flagged;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fifo_flagged_if #(.DEPTH(8), .DATA_WIDTH(8)) b0 ();
    fifo_flagged_if #(.DEPTH(8), .DATA_WIDTH(8)) b1 ();

    fifo_flagged #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0.slave)
    );

    fifo_flagged #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; outputs then show post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] e;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        b0.clr = 1'b0; b0.wren = 1'b0; b0.rden = 1'b0; b0.i_data = '0;
        b1.clr = 1'b0; b1.wren = 1'b0; b1.rden = 1'b0; b1.i_data = '0;

        // 1: reset state, fill, overflow
        tick();
        check("rst_empty",  b0.empty, 1);
        check("rst_full",   b0.full, 0);
        check("rst_count",  b0.count, 0);
        check("rst_afull",  b0.almost_full, 0);
        check("rst_aempty", b0.almost_empty, 1);
        check("rst_ovf",    b0.overflow, 0);
        check("rst_udf",    b0.underflow, 0);
        check("rst_valid",  b0.o_valid, 0);
        check("rst_odata",  b0.o_data, 0);
        check("rst_fwft_valid", b1.o_valid, 0);
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            b0.wren = 1'b1; b0.i_data = 8'(i);
            tick();
            check("fill_count", b0.count, 32'(i));
            check("fill_afull", b0.almost_full, (i >= 7) ? 1 : 0);
            check("fill_full",  b0.full, (i == 8) ? 1 : 0);
        end
        b0.i_data = 8'hFF;
        tick();
        b0.wren = 1'b0;
        check("ovf_flag",  b0.overflow, 1);
        check("ovf_count", b0.count, 8);

        // 2: drain with 1-cycle latency, then underflow
        for (int i = 1; i <= 8; i++) begin
            b0.rden = 1'b1;
            tick();
            check("drain_valid", b0.o_valid, 1);
            check("drain_data",  b0.o_data, 32'(i));
        end
        b0.rden = 1'b0;
        tick();
        check("drain_valid_off", b0.o_valid, 0);
        check("drain_empty",     b0.empty, 1);
        check("drain_hold_data", b0.o_data, 8'h08);
        b0.rden = 1'b1;
        tick();
        b0.rden = 1'b0;
        check("udf_flag",  b0.underflow, 1);
        check("udf_valid", b0.o_valid, 0);
        check("ovf_sticky", b0.overflow, 1);
        b0.rden = 1'b1; b0.wren = 1'b1; b0.i_data = 8'hC3;
        tick();
        b0.rden = 1'b0; b0.wren = 1'b0;
        check("empty_rw_count", b0.count, 1);
        check("empty_rw_valid", b0.o_valid, 0);
        b0.clr = 1'b1;
        tick();
        b0.clr = 1'b0;
        check("clr_ovf",   b0.overflow, 0);
        check("clr_udf",   b0.underflow, 0);
        check("clr_count", b0.count, 0);

        // 3: write while full with simultaneous read
        for (int i = 0; i < 8; i++) begin
            b0.wren = 1'b1; b0.i_data = 8'(8'h10 + i);
            tick();
        end
        b0.rden = 1'b1; b0.i_data = 8'hAA;
        tick();
        b0.wren = 1'b0;
        check("wwf_ovf",   b0.overflow, 0);
        check("wwf_count", b0.count, 8);
        check("wwf_data",  b0.o_data, 8'h10);
        for (int i = 0; i < 8; i++) begin
            tick();
            e = (i == 7) ? 8'hAA : 8'(8'h11 + i);
            check("wwf_drain", b0.o_data, e);
        end
        b0.rden = 1'b0;
        tick();
        check("wwf_empty", b0.empty, 1);

        // 4: interleaved traffic keeping count in 3..6, pointers wrap
        for (int i = 0; i < 3; i++) begin
            b0.wren = 1'b1; b0.i_data = 8'(8'h20 + i); q.push_back(8'(8'h20 + i));
            tick();
        end
        b0.wren = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ((i % 6) < 3) begin
                b0.wren = 1'b1; b0.i_data = 8'(8'h30 + i); q.push_back(8'(8'h30 + i));
                tick();
                b0.wren = 1'b0;
            end else begin
                b0.rden = 1'b1;
                tick();
                b0.rden = 1'b0;
                e = q.pop_front();
                check("ilv_data",  b0.o_data, e);
                check("ilv_valid", b0.o_valid, 1);
            end
            check("ilv_afull",  b0.almost_full, 0);
            check("ilv_aempty", b0.almost_empty, 0);
        end
        check("ilv_count", b0.count, 3);
        check("ilv_ovf",   b0.overflow, 0);
        check("ilv_udf",   b0.underflow, 0);

        // 5: fall-through read
        b1.wren = 1'b1; b1.i_data = 8'h5A;
        tick();
        b1.wren = 1'b0;
        check("fwft_valid", b1.o_valid, 1);
        check("fwft_data",  b1.o_data, 8'h5A);
        tick();
        check("fwft_hold",  b1.o_data, 8'h5A);
        b1.rden = 1'b1;
        tick();
        b1.rden = 1'b0;
        check("fwft_empty", b1.empty, 1);
        check("fwft_valid_off", b1.o_valid, 0);
        b1.wren = 1'b1; b1.i_data = 8'h11;
        tick();
        b1.i_data = 8'h22;
        tick();
        b1.wren = 1'b0;
        check("fwft_first", b1.o_data, 8'h11);
        b1.rden = 1'b1;
        tick();
        b1.rden = 1'b0;
        check("fwft_second",  b1.o_data, 8'h22);
        check("fwft_valid2",  b1.o_valid, 1);

        // 6: flush and async reset with a write pending
        for (int i = 0; i < 2; i++) begin
            b0.wren = 1'b1; b0.i_data = 8'(8'h60 + i);
            tick();
        end
        check("pre_clr_count", b0.count, 5);
        b0.clr = 1'b1; b0.i_data = 8'h77;
        tick();
        b0.clr = 1'b0; b0.wren = 1'b0;
        check("clr_count5", b0.count, 0);
        check("clr_empty",  b0.empty, 1);
        check("clr_valid",  b0.o_valid, 0);
        check("clr_odata",  b0.o_data, 0);
        check("clr_afull",  b0.almost_full, 0);
        b0.wren = 1'b1; b0.i_data = 8'h42;
        tick();
        b0.wren = 1'b0; b0.rden = 1'b1;
        tick();
        b0.rden = 1'b0;
        check("post_clr_data", b0.o_data, 8'h42);
        for (int i = 0; i < 5; i++) begin
            b0.wren = 1'b1; b0.i_data = 8'(8'h80 + i);
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", b0.count, 0);
        check("arst_empty", b0.empty, 1);
        check("arst_aempty", b0.almost_empty, 1);
        tick();
        b0.wren = 1'b0;
        rst_n = 1'b1;
        tick();
        check("arst_still_empty", b0.empty, 1);
        check("arst_fwft_empty",  b1.empty, 1);
        b0.wren = 1'b1; b0.i_data = 8'h99;
        tick();
        b0.wren = 1'b0; b0.rden = 1'b1;
        tick();
        b0.rden = 1'b0;
        check("post_rst_data",  b0.o_data, 8'h99);
        check("post_rst_valid", b0.o_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
